hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. Observes register indices and control bits from the D, E, M and W stages, and drives the stall (hold) and clear (flush) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Also produces the EX-stage forwarding selects. A small state machine freezes the pipeline during multi-cycle data-memory accesses and latches a timeout error.

## Interface
- `MEM_TIMEOUT`, default 16: maximum number of MWAIT cycles before the error state; legal range 2..255.
- `CNT_W`, default 32: width of the performance counters.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rs1_d`, `rs2_d`  in  5  source registers of the instruction in D.
- `rs1_e`, `rs2_e`  in  5  source registers of the instruction in E.
- `rd_e`, `rd_m`, `rd_w`  in  5  destination registers in E, M and W.
- `load_e`  in  1  instruction in E is a load.
- `reg_write_m`, `reg_write_w`  in  1  instruction in M / W writes the register file.
- `pc_src_e`  in  1  taken branch or jump resolved in E.
- `mem_req_m`  in  1  instruction in M accesses data memory.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `stall_f`, `stall_d`, `stall_e`, `stall_m`  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers (1 = hold; maps to the register `en` input).
- `flush_d`, `flush_e`, `flush_w`  out  1  clear IF/ID, ID/EX and MEM/WB (maps to `clr`).
- `fwd_a_e`, `fwd_b_e`  out  2  ALU operand select: 00 = register file, 01 = W result, 10 = M result.
- `mem_err`  out  1  sticky memory timeout flag.
- `lu_stall_cnt`, `mem_stall_cnt`, `flush_cnt`  out  `CNT_W`  performance counters.

## Operation
- **States:** RUN, MWAIT, ERR (registered). A wait counter `wcnt` (8 bits) is also registered.
- **Forwarding (combinational)**
  - `fwd_a_e` = 10 if `reg_write_m` & `rd_m`≠0 & `rd_m`==`rs1_e`.
  - Otherwise 01 if `reg_write_w` & `rd_w`≠0 & `rd_w`==`rs1_e`.
  - Otherwise 00.
  - `fwd_b_e` uses the same rule with `rs2_e`.
  - When both M and W match, M wins.
- **Load-use condition:** `lu` = `load_e` & `rd_e`≠0 & (`rd_e`==`rs1_d` | `rd_e`==`rs2_d`).
- **Memory freeze condition:** `frz` = (state==RUN & `mem_req_m` & ~`mem_ready`) | (state==MWAIT & ~`mem_ready`) | state==ERR.
- **Output priority, highest first:**
  1. `frz`: `stall_f`=`stall_d`=`stall_e`=`stall_m`=1, `flush_w`=1, all other flushes 0. A pending `pc_src_e` or `lu` is held, not lost, because E and D are frozen.
  2. `pc_src_e`: `flush_d`=`flush_e`=1, all stalls 0. This overrides `lu`, because the stalled instruction is squashed anyway.
  3. `lu`: `stall_f`=`stall_d`=1, `flush_e`=1 (bubble into E).
  4. Otherwise all control outputs are 0.
- **Transitions**
  - RUN → MWAIT when `mem_req_m` & ~`mem_ready`; `wcnt` ← 1.
  - MWAIT → RUN when `mem_ready`. The pipeline releases combinationally in that same cycle; `wcnt` ← 0.
  - MWAIT → ERR when ~`mem_ready` & `wcnt`==`MEM_TIMEOUT`-1. Otherwise `wcnt`++.
  - ERR is absorbing until `rst`. `mem_err`=1 in ERR; the pipeline stays frozen.
- **Reset:** state RUN, `wcnt` 0, `mem_err` 0, counters 0. While `rst`=1, every stall, flush and forwarding output is driven 0. A reset asserted during MWAIT or ERR returns the block to RUN on the next edge.

## Timing
- Stall, flush and forwarding outputs are combinational from the current-cycle inputs and the registered state. There is no added latency; they act on the pipeline registers at the next edge.
- **Load-use:** exactly one bubble per load-use pair. In the next cycle the load is in M, `lu` drops, and forwarding selects M.
- **Taken branch:** one cycle of `flush_d`/`flush_e`, costing two squashed instructions.
- **Memory access:** N wait cycles (`mem_ready` low for N cycles after `mem_req_m`) give N freeze cycles. ERR is entered on the edge ending the `MEM_TIMEOUT`-th wait cycle.
- `mem_err` is registered: it rises one cycle after the timeout edge condition.

## Configuration
- Macro `HAZARD_PERF_CNT_EN`.
  - **Defined:** counters increment by 1 per cycle, wrapping at 2^`CNT_W`.
    - `lu_stall_cnt` counts cycles where `lu` is the active cause.
    - `mem_stall_cnt` counts `frz` cycles.
    - `flush_cnt` counts cycles with `pc_src_e` active and not frozen.
  - **Undefined:** the counter registers are not built, and all three ports are tied to 0. Ports exist in both builds.

## Test plan
- Forwarding: `rs1_e`=5, `rd_m`=5, `reg_write_m`=1, `rd_w`=5, `reg_write_w`=1 → `fwd_a_e`=10. With `rd_m`=0 instead → `fwd_a_e`=01.
- Load-use: `load_e`=1, `rd_e`=3, `rs2_d`=3 → one cycle of `stall_f`=`stall_d`=`flush_e`=1, then all 0 once the load moves to M.
- Branch over load-use: `lu`=1 and `pc_src_e`=1 in the same cycle → `flush_d`=`flush_e`=1, `stall_f`=`stall_d`=0. `flush_cnt` increments (macro defined).
- Memory wait: `mem_req_m`=1 with `mem_ready` low for 3 cycles, then high → 3 cycles of all stalls plus `flush_w`=1, release in the `mem_ready` cycle, `mem_stall_cnt`=3.
- Timeout with `MEM_TIMEOUT`=4: `mem_ready` held low → ERR, `mem_err`=1 sticky, pipeline frozen. Pulse `rst` → `mem_err`=0, state RUN, outputs 0.
- Reset mid-MWAIT: `rst` asserted in the 2nd wait cycle → all outputs 0 during `rst`. After release with `mem_req_m`=0, no stall.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline-side observations in, stall/flush/forward
// controls and performance counters out.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e;
  logic [4:0]       rd_e, rd_m, rd_w;
  logic             load_e, reg_write_m, reg_write_w, pc_src_e;
  logic             mem_req_m, mem_ready;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;
  logic [1:0]       fwd_a_e, fwd_b_e;
  logic             mem_err;
  logic [CNT_W-1:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           load_e, reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           fwd_a_e, fwd_b_e, mem_err, lu_stall_cnt, mem_stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           load_e, reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ready,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           fwd_a_e, fwd_b_e, mem_err, lu_stall_cnt, mem_stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding, load-use bubbles, branch
// flushes and a memory-wait freeze FSM. Counters built under HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, MWAIT, ERR} state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       mem_err_q, mem_err_d;
  logic       lu, frz;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  // x0 is never forwarded; M is younger than W so it wins.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                         input logic wm, input logic [4:0] rdw,
                                         input logic ww);
    if (wm && rdm != 5'd0 && rdm == rs)      return 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
    else                                     return 2'b00;
  endfunction

  always_comb begin
    lu  = hz.load_e && hz.rd_e != 5'd0 && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
    frz = (state_q == RUN   && hz.mem_req_m && !hz.mem_ready) ||
          (state_q == MWAIT && !hz.mem_ready) ||
          (state_q == ERR);
  end

  always_comb begin
    stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
    flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;
    fwd_a   = 2'b00; fwd_b  = 2'b00;
    if (!rst) begin
      fwd_a = fwd_sel(hz.rs1_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);
      fwd_b = fwd_sel(hz.rs2_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);
      // Freeze holds E and D, so a pending branch or load-use survives it.
      if (frz) begin
        stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hz.pc_src_e) begin
        flush_d = 1'b1; flush_e = 1'b1;
      end else if (lu) begin
        stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    case (state_q)
      RUN: if (hz.mem_req_m && !hz.mem_ready) begin
        state_d = MWAIT;
        wcnt_d  = 8'd1;
      end
      MWAIT: if (hz.mem_ready) begin
        state_d = RUN;
        wcnt_d  = 8'd0;
      end else if (wcnt_q == WAIT_LAST) begin
        state_d = ERR;
      end else begin
        wcnt_d  = wcnt_q + 8'd1;
      end
      default: state_d = ERR;
    endcase
    mem_err_d = mem_err_q || (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wcnt_q    <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, mem_cnt_q, mem_cnt_d, fl_cnt_q, fl_cnt_d;

  always_comb begin
    lu_cnt_d  = lu_cnt_q  + CNT_W'(lu && !frz && !hz.pc_src_e);
    mem_cnt_d = mem_cnt_q + CNT_W'(frz);
    fl_cnt_d  = fl_cnt_q  + CNT_W'(hz.pc_src_e && !frz);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      lu_cnt_q  <= lu_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
    end
  end

  assign hz.lu_stall_cnt  = lu_cnt_q;
  assign hz.mem_stall_cnt = mem_cnt_q;
  assign hz.flush_cnt     = fl_cnt_q;
`else
  assign hz.lu_stall_cnt  = {CNT_W{1'b0}};
  assign hz.mem_stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt     = {CNT_W{1'b0}};
`endif

  assign hz.stall_f = stall_f;
  assign hz.stall_d = stall_d;
  assign hz.stall_e = stall_e;
  assign hz.stall_m = stall_m;
  assign hz.flush_d = flush_d;
  assign hz.flush_e = flush_e;
  assign hz.flush_w = flush_w;
  assign hz.fwd_a_e = fwd_a;
  assign hz.fwd_b_e = fwd_b;
  assign hz.mem_err = mem_err_q;

endmodule
